// File: rtl/note_sequencer.sv
// note_sequencer: steps through a small note table and drives one external prescale counter.
// Optional NOTE_SEQ_ARTICULATION_EN adds a silent GAP state, lasting one beat, between notes.
module note_sequencer #(
  parameter int unsigned PRESCALER_BITS = 1,
  parameter int unsigned COUNTER_BITS   = 16,
  parameter int unsigned DURATION_BITS  = 8,
  parameter int unsigned ADDR_BITS      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [ADDR_BITS-1:0]      wr_addr,
  input  logic [COUNTER_BITS-1:0]   wr_counter_preset,
  input  logic [DURATION_BITS-1:0]  wr_duration,
  input  logic                      wr_last,
  input  logic [PRESCALER_BITS-1:0] prescaler_cfg,
  input  logic                      loop,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      beat_tick,
  output logic                      cnt_rst,
  output logic [PRESCALER_BITS-1:0] cnt_prescaler_preset,
  output logic [COUNTER_BITS-1:0]   cnt_counter_preset,
  output logic                      tone_en,
  output logic                      busy,
  output logic [ADDR_BITS-1:0]      step_index,
  output logic                      done
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {StIdle, StLoad, StPlay, StGap, StDone} state_t;

  logic [COUNTER_BITS-1:0]   r_tbl_preset [DEPTH];
  logic [DURATION_BITS-1:0]  r_tbl_dur    [DEPTH];
  logic                      r_tbl_last   [DEPTH];

  state_t                    r_state;
  logic [ADDR_BITS-1:0]      r_index;
  logic [COUNTER_BITS-1:0]   r_preset;
  logic [DURATION_BITS-1:0]  r_beats;
  logic                      r_last;
  logic [PRESCALER_BITS-1:0] r_presc;
  logic                      r_cnt_rst;
  logic                      r_tone_en;
  logic                      r_busy;
  logic                      r_done;

  state_t                    w_state_d;
  state_t                    w_adv_state;
  logic [ADDR_BITS-1:0]      w_index_d;
  logic [ADDR_BITS-1:0]      w_adv_index;
  logic [DURATION_BITS-1:0]  w_beats_d;
  logic                      w_wrap;

  // Table storage has no reset; firmware fills it before start.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_tbl_preset[wr_addr] <= wr_counter_preset;
      r_tbl_dur[wr_addr]    <= wr_duration;
      r_tbl_last[wr_addr]   <= wr_last;
    end
  end

  always_comb begin
    w_wrap      = r_last || (r_index == LAST_IDX);
    w_adv_state = StLoad;
    w_adv_index = r_index + 1'b1;
    if (w_wrap) begin
      w_adv_index = '0;
      w_adv_state = loop ? StLoad : StDone;
    end

    w_state_d = r_state;
    w_index_d = r_index;
    w_beats_d = r_beats;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StLoad;
          w_index_d = '0;
        end
      end
      StLoad: w_state_d = StPlay;
      StPlay: begin
        if (beat_tick) begin
          if (r_beats <= DURATION_BITS'(1)) begin
`ifdef NOTE_SEQ_ARTICULATION_EN
            w_state_d = StGap;
`else
            w_state_d = w_adv_state;
            w_index_d = w_adv_index;
`endif
          end else begin
            w_beats_d = r_beats - DURATION_BITS'(1);
          end
        end
      end
      StGap: begin
        if (beat_tick) begin
          w_state_d = w_adv_state;
          w_index_d = w_adv_index;
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    if (stop) begin
      w_state_d = StIdle;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_index   <= '0;
      r_preset  <= '0;
      r_beats   <= '0;
      r_last    <= 1'b0;
      r_presc   <= '0;
      r_cnt_rst <= 1'b1;
      r_tone_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_presc   <= prescaler_cfg;
      r_cnt_rst <= (w_state_d != StPlay);
      r_busy    <= (w_state_d inside {StLoad, StPlay, StGap});
      r_done    <= (w_state_d == StDone);
      // r_preset already holds the new note when moving LOAD -> PLAY.
      r_tone_en <= (w_state_d == StPlay) && (r_preset != '0);
      if (w_state_d == StLoad) begin
        r_index  <= w_index_d;
        r_preset <= r_tbl_preset[w_index_d];
        r_beats  <= r_tbl_dur[w_index_d];
        r_last   <= r_tbl_last[w_index_d];
      end else begin
        r_beats  <= w_beats_d;
      end
    end
  end

  assign cnt_rst              = r_cnt_rst;
  assign cnt_prescaler_preset = r_presc;
  assign cnt_counter_preset   = r_preset;
  assign tone_en              = r_tone_en;
  assign busy                 = r_busy;
  assign step_index           = r_index;
  assign done                 = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios followed by random traffic,
// compared every cycle against a beat-level behavioural model of the sequencer.
module tb_note_sequencer;

  localparam int DEPTH = 16;
`ifdef NOTE_SEQ_ARTICULATION_EN
  localparam bit ART = 1'b1;
`else
  localparam bit ART = 1'b0;
`endif

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_PLAY = 2;
  localparam int PH_GAP  = 3;
  localparam int PH_DONE = 4;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_counter_preset;
  logic [7:0]  wr_duration;
  logic        wr_last;
  logic [0:0]  prescaler_cfg;
  logic        loop;
  logic        start;
  logic        stop;
  logic        beat_tick;
  logic        cnt_rst;
  logic [0:0]  cnt_prescaler_preset;
  logic [15:0] cnt_counter_preset;
  logic        tone_en;
  logic        busy;
  logic [3:0]  step_index;
  logic        done;

  note_sequencer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .wr_en                (wr_en),
    .wr_addr              (wr_addr),
    .wr_counter_preset    (wr_counter_preset),
    .wr_duration          (wr_duration),
    .wr_last              (wr_last),
    .prescaler_cfg        (prescaler_cfg),
    .loop                 (loop),
    .start                (start),
    .stop                 (stop),
    .beat_tick            (beat_tick),
    .cnt_rst              (cnt_rst),
    .cnt_prescaler_preset (cnt_prescaler_preset),
    .cnt_counter_preset   (cnt_counter_preset),
    .tone_en              (tone_en),
    .busy                 (busy),
    .step_index           (step_index),
    .done                 (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done_seen = 0;

  // Reference model: table plus the currently playing note.
  int t_preset [DEPTH];
  int t_dur    [DEPTH];
  int t_last   [DEPTH];
  int m_phase, m_idx, m_preset, m_left, m_last, m_presc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_idx = 0; m_preset = 0; m_left = 0; m_last = 0; m_presc = 0;
  endtask

  task automatic m_load(input int i);
    m_phase  = PH_LOAD;
    m_idx    = i;
    m_preset = t_preset[i];
    m_left   = (t_dur[i] == 0) ? 1 : t_dur[i];
    m_last   = t_last[i];
  endtask

  task automatic m_advance();
    if (m_last != 0 || m_idx == DEPTH - 1) begin
      if (loop) m_load(0);
      else m_phase = PH_DONE;
    end else begin
      m_load(m_idx + 1);
    end
  endtask

  task automatic model_edge();
    if (stop) begin
      m_phase = PH_IDLE;
    end else begin
      case (m_phase)
        PH_IDLE: if (start) m_load(0);
        PH_LOAD: m_phase = PH_PLAY;
        PH_PLAY: begin
          if (beat_tick) begin
            m_left--;
            if (m_left == 0) begin
              if (ART) m_phase = PH_GAP;
              else m_advance();
            end
          end
        end
        PH_GAP:  if (beat_tick) m_advance();
        PH_DONE: m_phase = PH_IDLE;
        default: m_phase = PH_IDLE;
      endcase
    end
    if (wr_en) begin
      t_preset[wr_addr] = int'(wr_counter_preset);
      t_dur[wr_addr]    = int'(wr_duration);
      t_last[wr_addr]   = int'(wr_last);
    end
    m_presc = int'(prescaler_cfg);
  endtask

  task automatic check_outputs();
    logic e_busy, e_rst, e_done, e_tone;
    e_rst  = (m_phase != PH_PLAY);
    e_busy = (m_phase == PH_LOAD) || (m_phase == PH_PLAY) || (m_phase == PH_GAP);
    e_done = (m_phase == PH_DONE);
    e_tone = (m_phase == PH_PLAY) && (m_preset != 0);
    chk("cnt_rst", 32'(cnt_rst), 32'(e_rst));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("tone_en", 32'(tone_en), 32'(e_tone));
    chk("step_index", 32'(step_index), 32'(m_idx));
    chk("cnt_counter_preset", 32'(cnt_counter_preset), 32'(m_preset));
    chk("cnt_prescaler_preset", 32'(cnt_prescaler_preset), 32'(m_presc));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (done === 1'b1) n_done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      beat_tick = 1'b1;
      cyc();
      beat_tick = 1'b0;
    end
  endtask

  task automatic write_entry(input int a, input int p, input int d, input int l);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_counter_preset = 16'(p);
    wr_duration = 8'(d);
    wr_last = 1'(l);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      t_preset[i] = 0; t_dur[i] = 0; t_last[i] = 0;
    end
    rst_n = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_counter_preset = '0; wr_duration = '0; wr_last = 1'b0;
    prescaler_cfg = 1'b1; loop = 1'b0; start = 1'b0; stop = 1'b0; beat_tick = 1'b0;
    model_reset();

    // Reset state, checked while reset is held.
    #3 rst_n = 1'b0;
    #4 check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic two-note sequence, no loop.
    write_entry(0, 100, 2, 0);
    write_entry(1, 50, 1, 1);
    n_done_seen = 0;
    do_start();
    idle(1);
    ticks(1); idle(1); ticks(1); idle(1); ticks(1); idle(1); ticks(2);
    idle(3);
    chk("single_done_pulse", 32'(n_done_seen), 32'd1);

    // Rest note: silent for three beats.
    write_entry(0, 0, 3, 1);
    do_start();
    idle(1);
    ticks(1); idle(2); ticks(1); idle(1); ticks(2);
    idle(2);

    // Looping program, then abort.
    write_entry(0, 200, 2, 0);
    write_entry(1, 300, 1, 1);
    loop = 1'b1;
    n_done_seen = 0;
    do_start();
    idle(1);
    ticks(10);
    chk("loop_no_done", 32'(n_done_seen), 32'd0);
    do_stop();
    idle(1);
    loop = 1'b0;

    // start and stop together from IDLE.
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    idle(2);

    // Tick during LOAD is ignored; duration 0 plays one beat.
    write_entry(0, 40, 0, 0);
    write_entry(1, 60, 3, 1);
    do_start();
    ticks(10);
    idle(2);

    // Overwrite the active entry while it plays.
    write_entry(0, 100, 3, 1);
    loop = 1'b1;
    do_start();
    idle(1);
    ticks(1);
    write_entry(0, 77, 3, 1);
    chk("preset_held", 32'(cnt_counter_preset), 32'd100);
    ticks(6);
    idle(1);
    do_stop();
    loop = 1'b0;

    // Asynchronous reset mid-note.
    do_start();
    idle(1);
    ticks(1);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Random traffic over a fully written table.
    for (int i = 0; i < DEPTH; i++) begin
      write_entry(i, (i % 5 == 0) ? 0 : 16'($urandom_range(1, 65535)),
                  $urandom_range(0, 3), ($urandom % 4 == 0) ? 1 : 0);
    end
    for (int c = 0; c < 1500; c++) begin
      wr_en = ($urandom % 8 == 0);
      wr_addr = 4'($urandom_range(0, 15));
      wr_counter_preset = ($urandom % 4 == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      wr_duration = 8'($urandom_range(0, 3));
      wr_last = ($urandom % 4 == 0);
      beat_tick = ($urandom % 3 == 0);
      start = ($urandom % 20 == 0);
      stop = ($urandom % 60 == 0);
      if ($urandom % 50 == 0) loop = ~loop;
      prescaler_cfg = 1'($urandom);
      cyc();
    end
    wr_en = 1'b0; beat_tick = 1'b0; start = 1'b0;
    do_stop();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
